// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (diff = a - b), LSB first, one full-subtractor
// cell plus a borrow flop, with a start/busy/done handshake.
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] shift_a_q, shift_a_d;
   logic [WIDTH-1:0] shift_b_q, shift_b_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             bin_q, bin_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             borrow_q, borrow_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic             d_s;
   logic             bout_s;
   logic [WIDTH-1:0] res_next_s;

   // Full-subtractor cell on the current LSBs and the borrow flop.
   function automatic logic [1:0] full_sub(input logic x, input logic y, input logic bi);
      full_sub[0] = x ^ y ^ bi;
      full_sub[1] = (~x & y) | (~(x ^ y) & bi);
   endfunction

   // Combinational datapath for the bit being consumed this cycle.
   always_comb begin
      {bout_s, d_s} = full_sub(shift_a_q[0], shift_b_q[0], bin_q);
      res_next_s    = {d_s, res_q[WIDTH-1:1]};
   end

   // Next-state, datapath update and registered-output decode.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      shift_a_d = shift_a_q;
      shift_b_d = shift_b_q;
      res_d     = res_q;
      bin_d     = bin_q;
      diff_d    = diff_q;
      borrow_d  = borrow_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               shift_a_d = a;
               shift_b_d = b;
               res_d     = '0;
               bin_d     = 1'b0;
               cnt_d     = '0;
               state_d   = S_RUN;
            end else begin
               state_d   = S_IDLE;
            end
         end
         S_RUN: begin
            res_d     = res_next_s;
            shift_a_d = {1'b0, shift_a_q[WIDTH-1:1]};
            shift_b_d = {1'b0, shift_b_q[WIDTH-1:1]};
            bin_d     = bout_s;
            if (cnt_q == CW'(WIDTH - 1)) begin
               diff_d   = res_next_s;
               borrow_d = bout_s;
               state_d  = S_DONE;
            end else begin
               cnt_d    = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d == S_RUN);
      done_d = (state_d == S_DONE);
   end

   // State and datapath registers; everything clears on reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         shift_a_q <= '0;
         shift_b_q <= '0;
         res_q     <= '0;
         bin_q     <= 1'b0;
         diff_q    <= '0;
         borrow_q  <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         shift_a_q <= shift_a_d;
         shift_b_q <= shift_b_d;
         res_q     <= res_d;
         bin_q     <= bin_d;
         diff_q    <= diff_d;
         borrow_q  <= borrow_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign diff   = diff_q;
   assign borrow = borrow_q;

endmodule
